// File: rtl/keypad_pkg.sv
// Shared types and default dimensions for the matrix keypad scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Default keypad geometry and debounce length (in tick periods).
  localparam int DEF_ROWS      = 4;
  localparam int DEF_COLS      = 4;
  localparam int DEF_DEB_TICKS = 20;

endpackage : keypad_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs. The reset value is a
// parameter so idle-high (pulled-up) pins can start in their idle state.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make meta and q update together at the
    // edge, so q takes the old meta and the chain really is two flops deep.
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad reader: drives one row low per scan step, samples
// the synchronized columns on each tick, debounces press and release over
// DEB_TICKS ticks and emits a one-cycle key_valid pulse with the key code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [COLS-1:0]               col_in,
  output logic [ROWS-1:0]               row_out,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  output logic                          key_held
);

  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CODE_W = $clog2(ROWS*COLS);
  localparam int CNT_W  = $clog2(DEB_TICKS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_TICKS);

  // Synchronized column lines (active-low).
  logic [COLS-1:0] col_s;

  sync_2ff #(
    .WIDTH   (COLS),
    .RST_VAL ({COLS{1'b1}})
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  scan_state_t     state, state_n;
  logic [RW-1:0]   row_idx, row_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [RW-1:0]   cand_row, cand_row_n;
  logic [CW-1:0]   cand_col, cand_col_n;
  logic [CODE_W-1:0] code_n;
  logic            valid_n, held_n;
  logic            hit;
  logic [CW-1:0]   hit_col;

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    return (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
  endfunction

  function automatic logic [CODE_W-1:0] key_of(input logic [RW-1:0] r,
                                               input logic [CW-1:0] c);
    return CODE_W'(r) * CODE_W'(COLS) + CODE_W'(c);
  endfunction

  // Press detection: any low column; the lowest-index low column wins.
  always_comb begin
    hit     = ~&col_s;
    hit_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) hit_col = CW'(c);
    end
  end

  // Debounce counter increment, saturating at DEB_TICKS.
  assign cnt_inc = (cnt == DEB_MAX) ? cnt : cnt + 1'b1;

  // Next-state and next-output logic; everything acts only on tick cycles.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_n    = state;
    row_n      = row_idx;
    cnt_n      = cnt;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    code_n     = key_code;
    valid_n    = 1'b0;
    held_n     = key_held;

    if (tick) begin
      unique case (state)
        SCAN: begin
          if (hit) begin
            cand_row_n = row_idx;
            cand_col_n = hit_col;
            cnt_n      = CNT_W'(1);
            if (DEB_TICKS == 1) begin
              state_n = HELD;
              code_n  = key_of(row_idx, hit_col);
              valid_n = 1'b1;
              held_n  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            row_n = next_row(row_idx);
          end
        end

        DEBOUNCE: begin
          if (hit && hit_col == cand_col) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              state_n = HELD;
              code_n  = key_of(cand_row, cand_col);
              valid_n = 1'b1;
              held_n  = 1'b1;
            end
          end else begin
            // Lost or changed contact: rescan the same row on the next tick.
            state_n = SCAN;
            cnt_n   = '0;
          end
        end

        HELD: begin
          if (!hit) begin
            if (DEB_TICKS == 1) begin
              state_n = SCAN;
              held_n  = 1'b0;
              row_n   = next_row(row_idx);
              cnt_n   = '0;
            end else begin
              state_n = RELEASE;
              cnt_n   = CNT_W'(1);
            end
          end
        end

        RELEASE: begin
          if (!hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              state_n = SCAN;
              held_n  = 1'b0;
              row_n   = next_row(row_idx);
              cnt_n   = '0;
            end
          end else begin
            // Re-contact during release is bounce: back to HELD, no new pulse.
            state_n = HELD;
            cnt_n   = '0;
          end
        end
      endcase
    end
  end

  // State and registered outputs; row_out is decoded from the next row index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= '0;
      cnt       <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      row_out   <= ~ROWS'(1);
    end else begin
      state     <= state_n;
      row_idx   <= row_n;
      cnt       <= cnt_n;
      cand_row  <= cand_row_n;
      cand_col  <= cand_col_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
      row_out   <= ~(ROWS'(1) << row_n);
    end
  end

endmodule : keypad_scanner

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives col_in
// from row_out, and a tick-level behavioural model predicts every output.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int DEB      = 3;
  localparam int TICK_DIV = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   tick = 1'b0;
  logic [COLS-1:0]        col_in;
  logic [ROWS-1:0]        row_out;
  logic [3:0]             key_code;
  logic                   key_valid;
  logic                   key_held;

  // pressed[r*COLS+c] = 1 means key (r,c) is physically down.
  logic [ROWS*COLS-1:0]   pressed = '0;

  int n_vec    = 0;
  int n_bad    = 0;
  int n_pulses = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state (tick granularity).
  int m_row   = 0;
  int m_run   = 0;   // consecutive matching press samples while not held
  int m_rel   = 0;   // consecutive released samples while held
  int m_ccol  = 0;
  bit m_held  = 1'b0;
  bit m_valid = 1'b0;
  int m_code  = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .DEB_TICKS (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Keypad matrix: a column is pulled low when a pressed key sits on a driven row.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_out[r] == 1'b0 && pressed[r*COLS+c]) col_in[c] = 1'b0;
  end

  // Tick strobe: one cycle in every TICK_DIV, driven away from the active edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph   = (ph + 1) % TICK_DIV;
      tick = (ph == 0);
    end
  end

  // Reference model: what the scanner must do on each tick, from the key matrix.
  always @(posedge clk) begin
    int row, run, rel, ccol, code, col;
    bit held, valid;
    row = m_row; run = m_run; rel = m_rel; ccol = m_ccol;
    code = m_code; held = m_held; valid = 1'b0;
    if (rst) begin
      row = 0; run = 0; rel = 0; ccol = 0; code = 0; held = 1'b0;
    end else if (tick) begin
      col = -1;
      for (int c = COLS - 1; c >= 0; c--)
        if (pressed[row*COLS+c]) col = c;
      if (!held) begin
        if (run == 0) begin
          if (col >= 0) begin run = 1; ccol = col; end
          else row = (row + 1) % ROWS;
        end else if (col == ccol) run++;
        else run = 0;
        if (run == DEB) begin
          held = 1'b1; valid = 1'b1; code = row*COLS + ccol; run = 0; rel = 0;
        end
      end else begin
        if (col < 0) begin
          rel++;
          if (rel == DEB) begin held = 1'b0; rel = 0; row = (row + 1) % ROWS; end
        end else rel = 0;
      end
    end
    m_row <= row; m_run <= run; m_rel <= rel; m_ccol <= ccol;
    m_code <= code; m_held <= held; m_valid <= valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROWS-1:0] exp_row(input int r);
    logic [ROWS-1:0] v;
    v = ROWS'(1) << r;
    return ~v;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("row_out",   row_out,   exp_row(m_row));
      check("key_valid", key_valid, m_valid);
      check("key_held",  key_held,  m_held);
      check("key_code",  key_code,  m_code);
    end
  end

  // Pulse counter; samples the value registered in the previous cycle.
  always @(posedge clk) if (key_valid === 1'b1) n_pulses++;

  task automatic next_tick();
    do @(posedge clk); while (tick !== 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12*TICK_DIV; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin found = 1'b1; break; end
    end
    check(name, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, a, b, p0;
    bit found;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_row_out", row_out, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    rst = 1'b0;

    // Idle scan walks the rows.
    next_tick(); check("scan_r1", row_out, 4'b1101);
    next_tick(); check("scan_r2", row_out, 4'b1011);
    next_tick(); check("scan_r3", row_out, 4'b0111);
    next_tick(); check("scan_r0", row_out, 4'b1110);
    check("scan_held", key_held, 0);

    // Steady key 9 (row 2, col 1).
    pressed = '0; pressed[9] = 1'b1;
    wait_valid("key9_timeout");
    check("key9_code", key_code, 9);
    check("key9_held", key_held, 1);
    check("key9_row", row_out, 4'b1011);

    // Release of key 9 with a one-tick re-contact.
    next_tick();
    p0 = n_pulses;
    pressed = '0;
    next_tick();
    pressed[9] = 1'b1;
    next_tick();
    check("rel_bounce_held", key_held, 1);
    pressed = '0;
    next_tick();
    next_tick();
    check("rel_mid_held", key_held, 1);
    next_tick();
    check("rel_done_held", key_held, 0);
    check("rel_resume_row", row_out, 4'b0111);
    check("rel_no_pulse", n_pulses, p0);
    check("rel_code_kept", key_code, 9);

    // Key 3 (row 0, col 3) with a contact bounce on press.
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_tick();
      if (row_out == 4'b1110) begin found = 1'b1; break; end
    end
    check("wait_row0", found, 1);
    pressed = '0; pressed[3] = 1'b1;
    next_tick();
    pressed = '0;
    next_tick();
    pressed[3] = 1'b1;
    p0 = n_pulses;
    next_tick();
    next_tick();
    check("bounce_no_early", key_valid, 0);
    next_tick();
    check("bounce_valid", key_valid, 1);
    check("bounce_code", key_code, 3);
    next_tick();
    check("bounce_one_pulse", n_pulses, p0 + 1);
    pressed = '0;
    repeat (DEB + 1) next_tick();

    // Two columns in row 1: lowest column wins.
    pressed = '0; pressed[5] = 1'b1; pressed[6] = 1'b1;
    wait_valid("multi_timeout");
    check("multi_code", key_code, 5);
    pressed = '0;
    repeat (DEB + 1) next_tick();

    // Reset while debouncing with two matching samples.
    pressed = '0; pressed[10] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_tick();
      if (m_run == 2 && !m_held) begin found = 1'b1; break; end
    end
    check("reach_deb2", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_row_out", row_out, 4'b1110);
    check("mrst_key_valid", key_valid, 0);
    check("mrst_key_held", key_held, 0);
    check("mrst_key_code", key_code, 0);
    repeat (3) @(negedge clk);   // spans a tick edge: reset must win
    check("mrst_tick_row", row_out, 4'b1110);
    rst = 1'b0;
    next_tick();
    pressed = '0;
    repeat (2*DEB + 2) next_tick();

    // Randomized key activity, occasional resets.
    for (int seg = 0; seg < 250; seg++) begin
      k = $urandom_range(0, 99);
      if (k < 40) pressed = '0;
      else if (k < 80) begin
        pressed = '0; pressed[$urandom_range(0, 15)] = 1'b1;
      end else begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
        pressed = '0; pressed[a] = 1'b1; pressed[b] = 1'b1;
      end
      repeat ($urandom_range(1, 7)) next_tick();
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        next_tick();
      end
    end
    pressed = '0;
    repeat (8) next_tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_keypad_scanner
